// File: rtl/node_frame_feeder_pkg.sv
// Shared constants, frame layout and state encoding for the Huffman node feeder.
package node_frame_feeder_pkg;

   localparam int unsigned DEPTH      = 256;
   localparam int unsigned NUM_W      = 9;
   localparam int unsigned WEIGHT_W   = 27;
   localparam int unsigned NODE_W     = NUM_W + WEIGHT_W;
   localparam int unsigned ADDR_W     = $clog2(DEPTH);

   localparam logic [WEIGHT_W-1:0] MAX_WEIGHT = {WEIGHT_W{1'b1}};

   localparam int unsigned NUM_MSB    = NODE_W - 1;
   localparam int unsigned NUM_LSB    = WEIGHT_W;
   localparam int unsigned WEIGHT_MSB = WEIGHT_W - 1;
   localparam int unsigned WEIGHT_LSB = 0;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StStream,
      StWaitSort,
      StDone
   } state_e;

   function automatic logic [NODE_W-1:0] make_frame(input logic [NUM_W-1:0]    num,
                                                    input logic [WEIGHT_W-1:0] weight);
      logic [NODE_W-1:0] frame;
      frame                        = '0;
      frame[NUM_MSB:NUM_LSB]       = num;
      frame[WEIGHT_MSB:WEIGHT_LSB] = weight;
      return frame;
   endfunction

endpackage

// File: rtl/node_frame_feeder.sv
// Reads the symbol histogram and streams one burst of node frames into the selection
// network, then counts the sorted nodes coming back and signals completion.
module node_frame_feeder
   import node_frame_feeder_pkg::*;
#(
   parameter int unsigned ZERO_AS_MAX = 1
) (
   input  logic                clk,
   input  logic                rstN,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic                hist_rd_en,
   output logic [ADDR_W-1:0]   hist_addr,
   input  logic [WEIGHT_W-1:0] hist_rdata,
   output logic                net_wr,
   output logic [NODE_W-1:0]   net_in,
   input  logic                net_valid_in,
   output logic [NUM_W-1:0]    nonzero_cnt
);

   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
   localparam logic [NUM_W-1:0]  RET_FULL  = NUM_W'(DEPTH);

   state_e              state_q, state_d;
   logic                done_q, done_d;
   logic                rd_en_q, rd_en_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W-1:0]   frame_cnt_q, frame_cnt_d;
   logic                net_wr_q, net_wr_d;
   logic [NODE_W-1:0]   net_in_q, net_in_d;
   logic [NUM_W-1:0]    nz_cnt_q, nz_cnt_d;
   logic [NUM_W-1:0]    ret_cnt_q, ret_cnt_d;

   logic                start_ok;
   logic                counting;
   logic [WEIGHT_W-1:0] weight;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q     <= StIdle;
         done_q      <= 1'b0;
         rd_en_q     <= 1'b0;
         addr_q      <= '0;
         frame_cnt_q <= '0;
         net_wr_q    <= 1'b0;
         net_in_q    <= '0;
         nz_cnt_q    <= '0;
         ret_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         done_q      <= done_d;
         rd_en_q     <= rd_en_d;
         addr_q      <= addr_d;
         frame_cnt_q <= frame_cnt_d;
         net_wr_q    <= net_wr_d;
         net_in_q    <= net_in_d;
         nz_cnt_q    <= nz_cnt_d;
         ret_cnt_q   <= ret_cnt_d;
      end
   end

   // The first cycle of StDone is the done cycle; a start there is still ignored.
   assign start_ok = start && ((state_q == StIdle) || ((state_q == StDone) && !done_q));
   assign counting = (state_q == StStream) || (state_q == StWaitSort);
   assign weight   = ((ZERO_AS_MAX != 0) && (hist_rdata == '0)) ? MAX_WEIGHT : hist_rdata;

   always_comb begin
      state_d     = state_q;
      done_d      = 1'b0;
      rd_en_d     = rd_en_q;
      addr_d      = addr_q;
      frame_cnt_d = frame_cnt_q;
      net_wr_d    = 1'b0;
      net_in_d    = '0;
      nz_cnt_d    = nz_cnt_q;
      ret_cnt_d   = ret_cnt_q;

      if (counting && net_valid_in && (ret_cnt_q != RET_FULL)) begin
         ret_cnt_d = ret_cnt_q + 1'b1;
      end

      unique case (state_q)
         StIdle, StDone: begin
            if (start_ok) begin
               state_d     = StFetch;
               rd_en_d     = 1'b1;
               addr_d      = '0;
               frame_cnt_d = '0;
               nz_cnt_d    = '0;
               ret_cnt_d   = '0;
            end
         end
         StFetch: begin
            state_d = StStream;
            addr_d  = addr_q + 1'b1;
         end
         StStream: begin
            // Data arriving now belongs to the address issued one cycle earlier.
            net_wr_d    = 1'b1;
            net_in_d    = make_frame(NUM_W'(frame_cnt_q), weight);
            frame_cnt_d = frame_cnt_q + 1'b1;
            if (hist_rdata != '0) begin
               nz_cnt_d = nz_cnt_q + 1'b1;
            end
            if (addr_q == ADDR_LAST) begin
               rd_en_d = 1'b0;
            end else begin
               addr_d = addr_q + 1'b1;
            end
            if (frame_cnt_q == ADDR_LAST) begin
               state_d = StWaitSort;
            end
         end
         StWaitSort: begin
            if (ret_cnt_d == RET_FULL) begin
               state_d = StDone;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign busy        = (state_q == StFetch) || (state_q == StStream) ||
                        (state_q == StWaitSort) || done_q;
   assign done        = done_q;
   assign hist_rd_en  = rd_en_q;
   assign hist_addr   = addr_q;
   assign net_wr      = net_wr_q;
   assign net_in      = net_in_q;
   assign nonzero_cnt = nz_cnt_q;

endmodule

// File: tb/tb_node_frame_feeder.sv
// Bench for node_frame_feeder: histogram RAM and selection-network models around the DUT,
// with frames and completion timing checked against expectations built from the histogram.
module tb_node_frame_feeder;

   localparam int N = 256;

   logic        clk;
   logic        rstN;
   logic        start;
   logic        busy;
   logic        done;
   logic        hist_rd_en;
   logic [7:0]  hist_addr;
   logic [26:0] hist_rdata;
   logic        net_wr;
   logic [35:0] net_in;
   logic        net_valid_in;
   logic [8:0]  nonzero_cnt;

   node_frame_feeder #(
      .ZERO_AS_MAX (1)
   ) dut (
      .clk          (clk),
      .rstN         (rstN),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .hist_rd_en   (hist_rd_en),
      .hist_addr    (hist_addr),
      .hist_rdata   (hist_rdata),
      .net_wr       (net_wr),
      .net_in       (net_in),
      .net_valid_in (net_valid_in),
      .nonzero_cnt  (nonzero_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Histogram RAM: one-cycle registered read.
   logic [26:0] hist [N];
   initial hist_rdata = '0;
   always @(posedge clk) if (hist_rd_en) hist_rdata <= hist[hist_addr];

   // Output capture, sampled mid-cycle.
   logic [35:0] frames [$];
   int          frame_cyc [$];
   int          done_seen = 0;
   int          stray     = 0;
   always @(negedge clk) begin
      if (net_wr) begin
         frames.push_back(net_in);
         frame_cyc.push_back(cyc);
      end else if (net_in !== '0) begin
         stray++;
      end
      if (done === 1'b1) done_seen++;
   end

   // Selection-network model: emits pulses until the requested total is reached.
   int sort_target    = 0;
   int sort_gap       = 1;
   int pulses_emitted = 0;
   int last_pulse_cyc = -10;
   int gap_cnt        = 0;
   initial begin
      net_valid_in = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (gap_cnt > 0) gap_cnt--;
         if ((pulses_emitted < sort_target) && (gap_cnt == 0)) begin
            net_valid_in = 1'b1;
            pulses_emitted++;
            last_pulse_cyc = cyc;
            gap_cnt = sort_gap;
         end else begin
            net_valid_in = 1'b0;
         end
      end
   end

   int checks = 0;
   int errors = 0;

   int start_cyc;
   int base_f;
   int base_d;
   int base_s;

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [35:0] exp_frame(input int n);
      logic [26:0] w;
      w = (hist[n] == 27'd0) ? 27'h7FFFFFF : hist[n];
      return {9'(n), w};
   endfunction

   function automatic int exp_nonzero();
      int c = 0;
      for (int i = 0; i < N; i++) if (hist[i] != 27'd0) c++;
      return c;
   endfunction

   task automatic mark_run(input int s);
      start_cyc = s;
      base_f    = frames.size();
      base_d    = done_seen;
      base_s    = stray;
   endtask

   task automatic issue_start();
      mark_run(cyc);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("fetch_rd_en", 64'(hist_rd_en), 64'(1));
      chk("fetch_addr", 64'(hist_addr), 64'(0));
      chk("fetch_busy", 64'(busy), 64'(1));
   endtask

   task automatic fill_random();
      logic [31:0] r;
      for (int i = 0; i < N; i++) begin
         r = $urandom;
         hist[i] = (r[1:0] == 2'b00) ? 27'd0 : r[31:5];
      end
   endtask

   task automatic complete_run(input int gap, input bit restart, input bit chain);
      int k;
      int nz;
      nz = exp_nonzero();
      k = 0;
      while (!net_wr && k < 10) begin
         tick();
         k++;
      end
      chk("first_wr_seen", 64'(net_wr), 64'(1));
      sort_gap    = gap;
      sort_target = pulses_emitted + N;
      if (restart) begin
         tick(10);
         chk("busy_at_restart", 64'(busy), 64'(1));
         start = 1'b1;
         tick();
         start = 1'b0;
      end
      k = 0;
      while (!done && k < N * gap + 400) begin
         tick();
         k++;
      end
      chk("done_seen", 64'(done), 64'(1));
      chk("done_latency", 64'(cyc), 64'(last_pulse_cyc + 1));
      chk("busy_in_done", 64'(busy), 64'(1));
      chk("nonzero_cnt", 64'(nonzero_cnt), 64'(nz));
      chk("hist_addr_hold", 64'(hist_addr), 64'(N - 1));
      chk("hist_rd_en_off", 64'(hist_rd_en), 64'(0));
      chk("frame_count", 64'(frames.size() - base_f), 64'(N));
      for (int i = 0; i < N && (base_f + i) < frames.size(); i++) begin
         chk($sformatf("frame_%0d", i), 64'(frames[base_f + i]), 64'(exp_frame(i)));
         chk($sformatf("frame_cyc_%0d", i), 64'(frame_cyc[base_f + i]),
             64'(start_cyc + 3 + i));
      end
      if (chain) start = 1'b1;
      tick();
      chk("done_one_cycle", 64'(done), 64'(0));
      chk("busy_after_done", 64'(busy), 64'(0));
      chk("single_done", 64'(done_seen - base_d), 64'(1));
      chk("no_stray_net_in", 64'(stray - base_s), 64'(0));
      if (chain) begin
         mark_run(cyc);
         tick();
         start = 1'b0;
         chk("chain_busy", 64'(busy), 64'(1));
         chk("chain_rd_en", 64'(hist_rd_en), 64'(1));
         chk("chain_nz_clear", 64'(nonzero_cnt), 64'(0));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      rstN  = 1'b0;
      start = 1'b0;
      for (int i = 0; i < N; i++) hist[i] = '0;
      tick(3);
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_rd_en", 64'(hist_rd_en), 64'(0));
      chk("rst_addr", 64'(hist_addr), 64'(0));
      chk("rst_net_wr", 64'(net_wr), 64'(0));
      chk("rst_net_in", 64'(net_in), 64'(0));
      chk("rst_nonzero", 64'(nonzero_cnt), 64'(0));
      rstN = 1'b1;
      tick(2);

      // Rising histogram, slow sorter.
      for (int i = 0; i < N; i++) hist[i] = 27'(i + 1);
      issue_start();
      complete_run(8, 1'b0, 1'b0);
      tick(3);

      // Zero counts alternate with 5.
      for (int i = 0; i < N; i++) hist[i] = (i % 2 == 0) ? 27'd0 : 27'd5;
      issue_start();
      complete_run(int'($urandom_range(1, 3)), 1'b0, 1'b0);
      tick(2);

      // Random histogram with a second start mid-stream.
      fill_random();
      issue_start();
      complete_run(2, 1'b1, 1'b0);
      tick(2);

      // All-zero histogram.
      for (int i = 0; i < N; i++) hist[i] = '0;
      issue_start();
      complete_run(1, 1'b0, 1'b0);
      tick(2);

      // Asynchronous reset in the middle of a burst.
      fill_random();
      issue_start();
      k = 0;
      while ((frames.size() - base_f) < 100 && k < 200) begin
         tick();
         k++;
      end
      chk("reached_frame_100", 64'(frames.size() - base_f), 64'(100));
      rstN = 1'b0;
      #1;
      chk("abort_net_wr", 64'(net_wr), 64'(0));
      chk("abort_busy", 64'(busy), 64'(0));
      chk("abort_rd_en", 64'(hist_rd_en), 64'(0));
      chk("abort_net_in", 64'(net_in), 64'(0));
      chk("abort_addr", 64'(hist_addr), 64'(0));
      chk("abort_nonzero", 64'(nonzero_cnt), 64'(0));
      base_d = done_seen;
      tick(3);
      chk("abort_no_done", 64'(done_seen - base_d), 64'(0));
      rstN = 1'b1;
      tick(2);

      // Sorter pulses while idle must not count toward the next run.
      base_d      = done_seen;
      sort_gap    = 1;
      sort_target = pulses_emitted + 20;
      tick(30);
      chk("idle_pulses_busy", 64'(busy), 64'(0));
      chk("idle_pulses_no_done", 64'(done_seen - base_d), 64'(0));
      fill_random();
      issue_start();
      complete_run(1, 1'b0, 1'b1);
      complete_run(3, 1'b0, 1'b0);
      tick(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
